// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding uart_tx through its start/done
// handshake. Optional sticky overflow flag enabled by defining the macro
// UART_TX_FIFO_OVERFLOW_EN (adds ports o_overflow and i_ovf_clr).
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_wr_en,
  input  logic [7:0]            i_wr_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_tx_start,
  output logic [7:0]            o_tx_data,
  input  logic                  i_tx_done,
  input  logic                  i_tx_busy
`ifdef UART_TX_FIFO_OVERFLOW_EN
  ,
  output logic                  o_overflow,
  input  logic                  i_ovf_clr
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, empty_q;
  logic                  start_q;
  logic [7:0]            tx_data_q;
  state_e                state_q, state_d;
  logic                  push, pop;

  // Push/pop qualification and next-state logic for pointers, count and FSM.
  // Pop decision uses the registered empty flag, so a byte pushed this
  // cycle cannot be launched on the same edge.
  always_comb begin
    push     = i_wr_en && !full_q;
    pop      = (state_q == ST_IDLE) && i_enable && !empty_q && !i_tx_busy;
    wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pop) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (i_tx_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Storage array: write-only here, no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_wr_data;
  end

  // Control registers; flags and start pulse are registered from next-state
  // values so every output comes straight from a flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      start_q   <= 1'b0;
      tx_data_q <= 8'h00;
      state_q   <= ST_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == FULL_CNT);
      empty_q  <= (count_d == '0);
      start_q  <= (state_d == ST_START);
      state_q  <= state_d;
      if (pop) tx_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_count    = count_q;
  assign o_tx_start = start_q;
  assign o_tx_data  = tx_data_q;

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: set by a push attempted while full; set beats clear.
  always_comb begin
    ovf_d = ovf_q;
    if (i_ovf_clr) ovf_d = 1'b0;
    if (i_wr_en && full_q) ovf_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo. The uart_tx handshake (done/busy)
// is driven by hand from each scenario task.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty;
  logic [4:0] count;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;
  logic       tx_busy = 1'b0;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic       ovf;
  logic       ovf_clr = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_enable   (enable),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .o_full     (full),
    .o_empty    (empty),
    .o_count    (count),
    .o_tx_start (tx_start),
    .o_tx_data  (tx_data),
    .i_tx_done  (tx_done),
    .i_tx_busy  (tx_busy)
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ,
    .o_overflow (ovf),
    .i_ovf_clr  (ovf_clr)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled at negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Acknowledge the byte in flight: one-cycle done pulse.
  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_cmp++; if (count !== 5'd0)   begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1)   begin n_bad++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0)    begin n_bad++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_start got %b want 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", tx_data); end
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    enable = 1'b1; tx_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    n_cmp++; if (count !== 5'd1)    begin n_bad++; $display("FAIL single_count1 got %0d want 1", count); end
    n_cmp++; if (empty !== 1'b0)    begin n_bad++; $display("FAIL single_empty0 got %b want 0", empty); end
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL single_nostart got %b want 0", tx_start); end
    tick();
    n_cmp++; if (tx_start !== 1'b1) begin n_bad++; $display("FAIL single_start got %b want 1", tx_start); end
    n_cmp++; if (tx_data !== 8'hA5) begin n_bad++; $display("FAIL single_data got %h want a5", tx_data); end
    n_cmp++; if (count !== 5'd0)    begin n_bad++; $display("FAIL single_count0 got %0d want 0", count); end
    tick();
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL single_pulse_len got %b want 0", tx_start); end
    pulse_done();
    tick();
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL single_restart got %b want 0", tx_start); end
    $display("test_single done: byte a5 launched");
  endtask

  task automatic test_wait_hold();
    int extra;
    enable = 1'b1;
    wr_en = 1'b1; wr_data = 8'hB1;
    tick();
    wr_data = 8'hB2;
    tick();
    wr_en = 1'b0;
    n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'hB1) begin n_bad++; $display("FAIL hold_first got %b/%h want 1/b1", tx_start, tx_data); end
    n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL hold_count got %0d want 1", count); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_start) extra++;
    end
    n_cmp++; if (extra !== 0)       begin n_bad++; $display("FAIL hold_extra_start got %0d want 0", extra); end
    n_cmp++; if (tx_data !== 8'hB1) begin n_bad++; $display("FAIL hold_data_stable got %h want b1", tx_data); end
    pulse_done();
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL hold_idle_gap got %b want 0", tx_start); end
    tick();
    n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'hB2) begin n_bad++; $display("FAIL hold_second got %b/%h want 1/b2", tx_start, tx_data); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL hold_count0 got %0d want 0", count); end
    tick();
    pulse_done();
    $display("test_wait_hold done");
  endtask

  task automatic test_burst();
    int waited;
    enable = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    n_cmp++; if (full !== 1'b1)   begin n_bad++; $display("FAIL burst_full got %b want 1", full); end
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL burst_count got %0d want 16", count); end
    wr_en = 1'b1; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL burst_drop_count got %0d want 16", count); end
`ifdef UART_TX_FIFO_OVERFLOW_EN
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", ovf); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clr got %b want 0", ovf); end
`endif
    enable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      waited = 0;
      while (!tx_start && waited < 8) begin
        tick();
        waited++;
      end
      n_cmp++;
      if (!tx_start) begin
        n_bad++; $display("FAIL burst_start_timeout byte %0d got no start want start", i);
      end else if (tx_data !== 8'(i)) begin
        n_bad++; $display("FAIL burst_data byte %0d got %h want %h", i, tx_data, 8'(i));
      end
      tick();
      pulse_done();
    end
    waited = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tx_start) waited++;
    end
    n_cmp++; if (waited !== 0)   begin n_bad++; $display("FAIL burst_extra_start got %0d want 0", waited); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL burst_empty got %b want 1", empty); end
    $display("test_burst done: 16 bytes streamed");
  endtask

  task automatic test_push_pop_wrap();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
      tick();
    end
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'h43 + 8'(i); enable = 1'b1;
      tick();
      wr_en = 1'b0;
      n_cmp++; if (count !== 5'd3) begin n_bad++; $display("FAIL wrap_count step %0d got %0d want 3", i, count); end
      n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h40 + 8'(i)) begin
        n_bad++; $display("FAIL wrap_data step %0d got %b/%h want 1/%h", i, tx_start, tx_data, 8'h40 + 8'(i));
      end
      tick();
      pulse_done();
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h51 + 8'(j) || count !== 5'(2 - j)) begin
        n_bad++; $display("FAIL wrap_drain %0d got %b/%h/%0d want 1/%h/%0d", j, tx_start, tx_data, count, 8'h51 + 8'(j), 2 - j);
      end
      tick();
      pulse_done();
    end
    $display("test_push_pop_wrap done: 20 bytes through depth 16");
  endtask

  task automatic test_reset_mid();
    int starts;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    enable = 1'b1;
    tick();
    n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h60) begin n_bad++; $display("FAIL rstmid_start got %b/%h want 1/60", tx_start, tx_data); end
    tick();
    tx_busy = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_flags got %0d/%b/%b want 0/1/0", count, empty, full);
    end
    n_cmp++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_out got %b/%h want 0/00", tx_start, tx_data); end
    @(negedge clk);
    rst_n = 1'b1;
    starts = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (tx_start) starts++; end
    tx_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); if (tx_start) starts++; end
    n_cmp++; if (starts !== 0)    begin n_bad++; $display("FAIL rstmid_nostart got %0d want 0", starts); end
    n_cmp++; if (count !== 5'd0)  begin n_bad++; $display("FAIL rstmid_count got %0d want 0", count); end
    wr_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL rstmid_push got %0d want 1", count); end
    tick();
    n_cmp++; if (tx_start !== 1'b1 || tx_data !== 8'h77) begin n_bad++; $display("FAIL rstmid_relaunch got %b/%h want 1/77", tx_start, tx_data); end
    tick();
    pulse_done();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_wait_hold();
    test_burst();
    test_push_pop_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
